// File: rtl/avg_rr_sched.sv
// Round-robin windowed averager: grants one requesting channel, reads WIN samples, divides the sum by WIN.
// Result appears WIN+ACC_W+2 cycles after the grant; no output backpressure, inputs are throttled by req/i_enable.
module avg_rr_sched #(
    parameter int N_CH  = 4,
    parameter int DW    = 8,
    parameter int WIN   = 53,
    parameter int ACC_W = 14,
    parameter int CH_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [N_CH-1:0]      req,
    input  logic [N_CH*DW-1:0]   s_data,
    output logic [N_CH-1:0]      rd_en,
    output logic                 o_valid,
    output logic [DW-1:0]        o_avg,
    output logic [CH_W-1:0]      o_ch,
    output logic                 o_busy
);
    localparam int CNT_W = $clog2(WIN);
    localparam int DIV_W = $clog2(ACC_W);
    localparam int REM_W = $clog2(WIN);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, DIV, OUT} state_t;

    state_t            state_q;
    logic [CH_W-1:0]   ptr_q, g_q, grant_ch_d;
    logic              grant_vld_d;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [ACC_W-1:0]  acc_q, acc_div_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [REM_W:0]    rem_sh;
    logic              div_ge;
    logic              rd_vld_q;
    logic [N_CH-1:0]   rd_en_q;
    logic              o_valid_q;
    logic [DW-1:0]     o_avg_q;
    logic [CH_W-1:0]   o_ch_q;
    logic [DW-1:0]     samp [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign samp[i] = s_data[i*DW +: DW];
    end

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) s = s - N_CH;
        return CH_W'(s);
    endfunction

    // Scan from farthest to nearest so the nearest requester after the pointer wins.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_ch_d  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (req[rr_idx(ptr_q, k)]) begin
                grant_vld_d = 1'b1;
                grant_ch_d  = rr_idx(ptr_q, k);
            end
        end
    end

    // Restoring divider step: acc_q doubles as dividend shifter and quotient collector.
    always_comb begin
        rem_sh    = {rem_q, acc_q[ACC_W-1]};
        div_ge    = rem_sh >= (REM_W+1)'(WIN);
        rem_d     = div_ge ? REM_W'(rem_sh - (REM_W+1)'(WIN)) : rem_sh[REM_W-1:0];
        acc_div_d = {acc_q[ACC_W-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= CH_W'(N_CH-1);
            g_q       <= '0;
            rd_cnt_q  <= '0;
            div_cnt_q <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_en_q   <= '0;
            o_valid_q <= 1'b0;
            o_avg_q   <= '0;
            o_ch_q    <= '0;
        end else begin
            o_valid_q <= 1'b0;
            rd_vld_q  <= |rd_en_q;
            case (state_q)
                IDLE: begin
                    if (i_enable && grant_vld_d) begin
                        g_q      <= grant_ch_d;
                        acc_q    <= '0;
                        rd_cnt_q <= '0;
                        rd_en_q  <= N_CH'(1) << grant_ch_d;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    if (rd_vld_q) acc_q <= acc_q + ACC_W'(samp[g_q]);
                    if (rd_cnt_q == CNT_W'(WIN-1)) begin
                        rd_en_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    acc_q     <= acc_q + ACC_W'(samp[g_q]);
                    rem_q     <= '0;
                    div_cnt_q <= '0;
                    state_q   <= DIV;
                end
                DIV: begin
                    acc_q <= acc_div_d;
                    rem_q <= rem_d;
                    if (div_cnt_q == DIV_W'(ACC_W-1)) begin
                        o_valid_q <= 1'b1;
                        o_avg_q   <= acc_div_d[DW-1:0];
                        o_ch_q    <= g_q;
                        state_q   <= OUT;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    ptr_q   <= g_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign o_valid = o_valid_q;
    assign o_avg   = o_avg_q;
    assign o_ch    = o_ch_q;
    assign o_busy  = (state_q != IDLE);
endmodule
